// File: rtl/counter_stream_gen_pkg.sv
// Shared definitions for the counter stream generator: opcodes, FSM encoding,
// checker classification codes and the per-opcode sample arithmetic.
package counter_stream_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_INCR   = 2'b01;
  localparam logic [1:0] OP_DECR   = 2'b10;
  localparam logic [1:0] OP_INJECT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EMIT = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  // Classification codes reported by the companion counter checker
  localparam logic [2:0] CHK_STABLE = 3'b000;
  localparam logic [2:0] CHK_INCR   = 3'b100;
  localparam logic [2:0] CHK_DECR   = 3'b010;
  localparam logic [2:0] CHK_ERROR  = 3'b001;

  function automatic logic [3:0] sample_value(input logic [1:0] op, input logic [3:0] cur);
    logic [3:0] v;
    case (op)
      OP_HOLD:   v = cur;
      OP_INCR:   v = cur + 4'd1;
      OP_DECR:   v = cur - 4'd1;
      OP_INJECT: v = cur + 4'd2;
      default:   v = cur;
    endcase
    return v;
  endfunction

  // An injected sample is an error on purpose, so the reference value stays put
  function automatic logic [3:0] next_cur(input logic [1:0] op, input logic [3:0] cur);
    logic [3:0] v;
    case (op)
      OP_INCR: v = cur + 4'd1;
      OP_DECR: v = cur - 4'd1;
      default: v = cur;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/counter_stream_gen_pace_timer.sv
// Idle-cycle pacer: loaded with the gap length, counts down, and flags the
// last idle cycle so the sequencer can return to emitting.
module pace_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] period,
  output logic       done
);

  logic [3:0] cnt_r;

  // Countdown register; loading period-1 makes done coincide with the final idle cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= period - 4'd1;
    end else if (en && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == 4'd0);

endmodule

// File: rtl/counter_stream_gen.sv
// Command-driven generator of paced modulo-16 sample streams for exercising the
// counter checker, including deliberate error injection.
module counter_stream_gen
  import counter_stream_pkg::*;
#(
  parameter int unsigned GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_count,
  output logic       valid,
  output logic [3:0] out,
  output logic       busy,
  output logic       err_injected
);

  localparam logic [3:0] GAP_V = 4'(GAP);

  state_e     state_r;
  state_e     state_s;
  logic [1:0] op_r;
  logic [3:0] rem_r;
  logic [3:0] cur_r;
  logic [3:0] out_r;
  logic       valid_r;
  logic       err_r;
  logic       accept_s;
  logic [1:0] op_sel_s;
  logic       timer_load_s;
  logic       timer_en_s;
  logic       timer_done_s;

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign accept_s  = cmd_valid && (state_r == ST_IDLE);
  // On the accept edge the latched opcode is not yet valid, so use the incoming one
  assign op_sel_s   = accept_s ? cmd_op : op_r;
  assign timer_en_s = (state_r == ST_GAP);

  pace_timer u_pace_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load_s),
    .en     (timer_en_s),
    .period (GAP_V),
    .done   (timer_done_s)
  );

  // Next-state decode and pacer load request
  always_comb begin
    state_s      = state_r;
    timer_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_EMIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (rem_r == 4'd0) begin
          state_s = ST_IDLE;
        end else if (GAP_V != 4'd0) begin
          state_s      = ST_GAP;
          timer_load_s = 1'b1;
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_GAP: begin
        if (timer_done_s) begin
          state_s = ST_EMIT;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command latch and remaining-sample count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r  <= OP_HOLD;
      rem_r <= 4'd0;
    end else if (accept_s) begin
      op_r  <= cmd_op;
      rem_r <= (cmd_op == OP_INJECT) ? 4'd0 : cmd_count;
    end else if ((state_r == ST_EMIT) && (rem_r != 4'd0)) begin
      op_r  <= op_r;
      rem_r <= rem_r - 4'd1;
    end else begin
      op_r  <= op_r;
      rem_r <= rem_r;
    end
  end

  // Sample outputs are computed on the edge entering EMIT so they are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      out_r   <= 4'd0;
      cur_r   <= 4'd0;
    end else if (state_s == ST_EMIT) begin
      valid_r <= 1'b1;
      err_r   <= (op_sel_s == OP_INJECT);
      out_r   <= sample_value(op_sel_s, cur_r);
      cur_r   <= next_cur(op_sel_s, cur_r);
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      out_r   <= out_r;
      cur_r   <= cur_r;
    end
  end

  assign valid        = valid_r;
  assign out          = out_r;
  assign err_injected = err_r;

endmodule

// File: tb/tb_counter_stream_gen.sv
// Randomised self-checking bench for counter_stream_gen: two instances (gap 0
// and gap 3) checked against a sample-list reference model and a checker model.
module tb_counter_stream_gen;
  import counter_stream_pkg::*;

  localparam int G0 = 0;
  localparam int G1 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid [2];
  logic [1:0] cmd_op    [2];
  logic [3:0] cmd_count [2];
  logic       cmd_ready [2];
  logic       valid     [2];
  logic [3:0] out_v     [2];
  logic       busy      [2];
  logic       err_inj   [2];

  always #5 clk = ~clk;

  counter_stream_gen #(.GAP(G0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_count(cmd_count[0]), .valid(valid[0]), .out(out_v[0]),
    .busy(busy[0]), .err_injected(err_inj[0]));

  counter_stream_gen #(.GAP(G1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_count(cmd_count[1]), .valid(valid[1]), .out(out_v[1]),
    .busy(busy[1]), .err_injected(err_inj[1]));

  typedef struct {
    int cyc;
    int v;
    int e;
  } smp_t;

  smp_t expq [2][$];
  smp_t gotq [2][$];
  int   mcur [2];
  int   last_out [2];
  int   chk_s [2];
  int   last_cyc [2];
  int   code_hist [2][8];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? G0 : G1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      gotq[d].delete();
      mcur[d]     = 0;
      last_out[d] = 0;
      chk_s[d]    = 0;
      last_cyc[d] = -100;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Monitor: collect samples, classify them like the checker, check idle behaviour
  initial begin
    smp_t s;
    int   c;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          chk_eq("busy_vs_ready", int'(busy[d]), int'(!cmd_ready[d]));
          if (valid[d]) begin
            s.cyc = cyc;
            s.v   = int'(out_v[d]);
            s.e   = int'(err_inj[d]);
            gotq[d].push_back(s);
            if (s.v == chk_s[d]) begin
              c = CHK_STABLE;
            end else if (s.v == ((chk_s[d] + 1) % 16)) begin
              c = CHK_INCR;
              chk_s[d] = s.v;
            end else if (s.v == ((chk_s[d] + 15) % 16)) begin
              c = CHK_DECR;
              chk_s[d] = s.v;
            end else begin
              c = CHK_ERROR;
            end
            code_hist[d][c]++;
            last_out[d] = s.v;
          end else begin
            chk_eq("out_hold_idle", int'(out_v[d]), last_out[d]);
            chk_eq("err_idle", int'(err_inj[d]), 0);
          end
        end
      end
    end
  end

  // Present a command at a negedge, wait for acceptance, and queue its expected samples
  task automatic issue(input int d, input int op, input int cnt, input bit hold_valid);
    int   c0;
    int   waited;
    int   acc;
    int   exp_acc;
    int   n;
    smp_t s;
    @(negedge clk);
    cmd_op[d]    = op[1:0];
    cmd_count[d] = cnt[3:0];
    cmd_valid[d] = 1'b1;
    c0     = cyc;
    waited = 0;
    while (!cmd_ready[d] && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready[d]) begin
      chk_eq("accept_timeout", int'(cmd_ready[d]), 1);
      cmd_valid[d] = 1'b0;
      return;
    end
    acc     = cyc + 1;
    exp_acc = (c0 + 1 > last_cyc[d] + 2) ? c0 + 1 : last_cyc[d] + 2;
    chk_eq("accept_cycle", acc, exp_acc);
    @(posedge clk);
    #1;
    if (!hold_valid) begin
      cmd_valid[d] = 1'b0;
      cmd_op[d]    = 2'($urandom);
      cmd_count[d] = 4'($urandom);
    end
    n = (op == 3) ? 1 : cnt + 1;
    for (int i = 0; i < n; i++) begin
      s.e = 0;
      case (op)
        1: mcur[d] = (mcur[d] + 1) % 16;
        2: mcur[d] = (mcur[d] + 15) % 16;
        default: ;
      endcase
      s.v = (op == 3) ? (mcur[d] + 2) % 16 : mcur[d];
      s.e = (op == 3) ? 1 : 0;
      s.cyc = exp_acc + i * (gap_of(d) + 1);
      expq[d].push_back(s);
      last_cyc[d] = s.cyc;
    end
  endtask

  // Wait for the instance to go idle, then compare collected samples with the model
  task automatic drain(input int d);
    int waited;
    int n;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready[d] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk_eq("drain_idle", int'(cmd_ready[d]), 1);
    chk_eq("sample_count", gotq[d].size(), expq[d].size());
    n = (gotq[d].size() < expq[d].size()) ? gotq[d].size() : expq[d].size();
    for (int i = 0; i < n; i++) begin
      chk_eq("sample_cycle", gotq[d][i].cyc, expq[d][i].cyc);
      chk_eq("sample_out", gotq[d][i].v, expq[d][i].v);
      chk_eq("sample_err", gotq[d][i].e, expq[d][i].e);
    end
    gotq[d].delete();
    expq[d].delete();
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk_eq("rst_valid", int'(valid[d]), 0);
      chk_eq("rst_out", int'(out_v[d]), 0);
      chk_eq("rst_err", int'(err_inj[d]), 0);
      chk_eq("rst_busy", int'(busy[d]), 0);
      chk_eq("rst_ready", int'(cmd_ready[d]), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int seen;
    int d;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_op[i]    = 2'b00;
      cmd_count[i] = 4'd0;
      for (int k = 0; k < 8; k++) code_hist[i][k] = 0;
    end
    model_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    #20 rst = 1'b0;

    snap = code_hist[0][CHK_INCR];
    issue(0, 1, 2, 1'b0);
    drain(0);
    chk_eq("incr3_codes", code_hist[0][CHK_INCR] - snap, 3);
    chk_eq("incr3_last", last_out[0], 3);

    issue(0, 2, 2, 1'b0);
    drain(0);
    issue(0, 2, 0, 1'b0);
    drain(0);
    chk_eq("wrap_down", last_out[0], 15);
    issue(0, 1, 0, 1'b0);
    drain(0);
    chk_eq("wrap_up", last_out[0], 0);

    issue(0, 2, 0, 1'b0);
    drain(0);
    snap = code_hist[0][CHK_ERROR];
    issue(0, 3, 9, 1'b0);
    drain(0);
    chk_eq("inject_code", code_hist[0][CHK_ERROR] - snap, 1);
    chk_eq("inject_out", last_out[0], 1);
    snap = code_hist[0][CHK_INCR];
    issue(0, 1, 0, 1'b0);
    drain(0);
    chk_eq("after_inject_code", code_hist[0][CHK_INCR] - snap, 1);
    chk_eq("after_inject_out", last_out[0], 0);

    snap = code_hist[1][CHK_STABLE];
    issue(1, 0, 1, 1'b0);
    drain(1);
    chk_eq("hold_gap_codes", code_hist[1][CHK_STABLE] - snap, 2);

    issue(0, 1, 3, 1'b1);
    issue(0, 2, 1, 1'b0);
    drain(0);
    issue(1, 1, 2, 1'b1);
    issue(1, 3, 0, 1'b0);
    drain(1);

    for (int it = 0; it < 30; it++) begin
      d = int'($urandom_range(1, 0));
      issue(d, int'($urandom_range(3, 0)), int'($urandom_range(15, 0)), 1'b1);
      issue(d, int'($urandom_range(3, 0)), int'($urandom_range(15, 0)), 1'b0);
      if ($urandom_range(1, 0) == 1) drain(d);
    end
    drain(0);
    drain(1);

    issue(0, 1, 15, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    seen = 0;
    foreach (expq[0][i]) if (expq[0][i].cyc <= cyc - 1) seen++;
    chk_eq("abort_seen_count", gotq[0].size(), seen);
    chk_eq("abort_valid", int'(valid[0]), 0);
    chk_eq("abort_out", int'(out_v[0]), 0);
    chk_eq("abort_ready", int'(cmd_ready[0]), 1);
    chk_eq("abort_busy", int'(busy[0]), 0);
    model_reset();
    #2 rst = 1'b0;
    issue(0, 1, 0, 1'b0);
    drain(0);
    chk_eq("post_reset_out", last_out[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_stream_gen.md
# counter_stream_gen

Transmit-side companion to the increment/decrement counter checker. Accepts step commands over a valid/ready handshake and emits a paced stream of 4-bit modulo-16 samples on `valid`/`out`, which connect directly to the checker's `valid`/`in`. It exists to drive the checker in system test and to inject deliberate errors, so the checker's STABLE/INCR/DECR/ERROR classification can be exercised end to end.

## Interface
- `GAP`, default 0: number of idle cycles (`valid`=0) inserted between consecutive samples of one command; legal range 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE.
- `cmd_op`  in  2  command opcode: 00 HOLD, 01 INCR, 10 DECR, 11 INJECT.
- `cmd_count`  in  4  number of samples minus 1, so 0..15 gives 1..16 samples; ignored for INJECT.
- `valid`  out  1  sample strobe, one cycle per sample.
- `out`  out  4  sample value; meaningful only when `valid`=1.
- `busy`  out  1  command in progress; the inverse of `cmd_ready`.
- `err_injected`  out  1  pulses with `valid` on an INJECT sample.

## Operation
- Internal registers:
  - `cur[3:0]` holds the last legally emitted value.
  - `remaining[3:0]` holds the samples left to emit.
  - `gap_cnt` counts idle cycles between samples.
  - Latched copy of `op`.
- Command accept: a command is accepted when `cmd_valid` && `cmd_ready`. On accept, `op` and `remaining`=`cmd_count` are latched; for INJECT, `remaining` is forced to 0.
- FSM states are IDLE, EMIT and GAP.
  - IDLE -> EMIT on accept.
  - EMIT is a single cycle with `valid`=1.
  - From EMIT: if `remaining`==0, go to IDLE. Otherwise decrement `remaining`, then go to GAP if `GAP`>0, or stay in EMIT if `GAP`=0.
  - GAP lasts exactly `GAP` cycles with `valid`=0, then returns to EMIT.
- Per-sample value for each opcode:
  - HOLD: `out`=`cur`; `cur` is unchanged.
  - INCR: `out`=`cur`+1 mod 16, and `cur` is updated to that value.
  - DECR: `out`=`cur`-1 mod 16, and `cur` is updated to that value.
  - INJECT: `out`=`cur`+2 mod 16 and `err_injected`=1; `cur` is NOT updated, matching the checker, which holds its state on ERROR.
- Wrap-around: 15+1 gives 0, 0-1 gives 15, and an INJECT at 15 or 14 gives 1 or 0 respectively.
- `cmd_valid` while busy: the command is not accepted; the source must hold it until `cmd_ready`. Changes to `cmd_op`/`cmd_count` while busy have no effect.
- Reset values:
  - State IDLE; `cur`=0 (matches the checker's reset state S0).
  - `valid`=0, `out`=0, `err_injected`=0, `busy`=0, `cmd_ready`=1.
- Reset mid-command: the command is abandoned immediately, with no further samples. `out`/`cur` return to 0 asynchronously.
- `out` holds its last value when `valid`=0.

## Timing
- All outputs are registered except `cmd_ready` and `busy`, which decode the FSM state.
- Latency: if a command is accepted at edge k, the first sample has `valid`=1 in the cycle after edge k.
- Sample spacing within one command is `GAP`+1 cycles.
- After the last sample, the block returns to IDLE at the next edge and `cmd_ready`=1 in that cycle. The earliest next accept is that edge, giving 1 dead cycle between commands when `GAP`=0.
- A command of N samples occupies N + (N-1)·`GAP` cycles of EMIT/GAP.

## Structure
- Package `counter_stream_pkg` holds:
  - Opcode constants `OP_HOLD`/`OP_INCR`/`OP_DECR`/`OP_INJECT`.
  - FSM state encodings IDLE/EMIT/GAP.
  - Checker output codes INCR=100, DECR=010, ERROR=001, STABLE=000, shared with the checker bench.
- One sub-module, `pace_timer`: it loads `GAP`, counts down, and asserts `done`. It is instantiated once and used for the GAP state.
- The FSM, `cur` update and command latch live in the top module.

## Test plan
- Reset, then INCR with `cmd_count`=2 and `GAP`=0 -> `valid` high for 3 consecutive cycles with `out`=1,2,3; the checker reports INCR three times.
- From `cur`=0, DECR with `cmd_count`=0 -> one sample with `out`=15; then INCR with `cmd_count`=0 -> `out`=0, exercising wrap in both directions.
- `cur`=15, INJECT -> `out`=1 and `err_injected`=1; the checker reports ERROR. A following INCR with `cmd_count`=0 -> `out`=0, and the checker reports INCR.
- `GAP`=3, HOLD with `cmd_count`=1 -> `valid` pulses exactly 4 cycles apart, both samples equal `cur`, and the checker reports STABLE.
- `cmd_valid` held high with a second command during a busy period -> the second command is accepted only on the edge where `cmd_ready`=1, with no sample lost or duplicated.
- `rst` asserted mid-way through an INCR with `cmd_count`=15 -> `valid`=0, `out`=0 and `cmd_ready`=1 immediately; the next INCR starts from `out`=1.
